replay_buffer_param: RTL

//  Parametrised data-link-layer replay buffer, successor to the fixed 128b/16b replay

---
 rtl/replay_buffer_param.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/replay_buffer_param.sv
// ---------------------------------------------------------------------------
// replay_buffer_param
//   Data-link-layer replay buffer. Holds up to DEPTH outgoing TLPs, tags each
//   with a modular sequence number and serialises them MSB-first onto an
//   OUT_W-bit link. ACK purges acknowledged TLPs. NAK or timer expiry replays
//   every outstanding transmitted TLP. Replay starts are counted, and a
//   rollover pulse is raised for link retrain.
//
// Ports
//   clk             rising-edge clock
//   reset_n         synchronous active-low reset
//   we / din        new TLP word; accepted only while ready=1
//   ready           a slot is free and no replay is running
//   ack_nack / seq  01=ACK, 10=NAK carrying sequence number seq
//   tim_out         replay timer expiry pulse
//   busy_n          downstream accepts the current beat this cycle
//   dout            current beat; dout_valid / dout_sof qualify it
//   next_seq        sequence number the next accepted write receives
//   count           outstanding (unpurged) TLPs
//   replay_rollover 1-cycle pulse when the replay counter rolls over
// ---------------------------------------------------------------------------
module replay_buffer_param #(
  parameter int IN_W       = 128,
  parameter int OUT_W      = 16,
  parameter int DEPTH      = 4,
  parameter int SEQ_W      = 12,
  parameter int REPLAY_MAX = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [IN_W-1:0]        din,
  output logic                   ready,
  input  logic [1:0]             ack_nack,
  input  logic [SEQ_W-1:0]       seq,
  input  logic                   tim_out,
  input  logic                   busy_n,
  output logic [OUT_W-1:0]       dout,
  output logic                   dout_valid,
  output logic                   dout_sof,
  output logic [SEQ_W-1:0]       next_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   replay_rollover
);

  localparam int BEATS = IN_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = $clog2(REPLAY_MAX + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    REPLAY = 2'd2
  } state_t;

  // Slots are addressed by the low bits of their sequence number, so the
  // read/transmit/write pointers are simply oldest_seq, tx_seq and next_seq.
  // Keeping full sequence numbers removes the empty/full pointer ambiguity.
  state_t           state;
  state_t           state_n;
  logic [IN_W-1:0]  mem [DEPTH];
  logic [IN_W-1:0]  shreg;        // word being serialised, current beat on top
  logic [SEQ_W-1:0] oldest_seq;   // oldest unpurged TLP
  logic [SEQ_W-1:0] tx_seq;       // first never-transmitted TLP
  logic [SEQ_W-1:0] cur_seq;      // TLP currently on the link
  logic [BW-1:0]    beat_idx;
  logic             pend;
  logic [RW-1:0]    replay_cnt;

  logic [SEQ_W-1:0] outstanding;
  logic [SEQ_W-1:0] s_off;
  logic [SEQ_W-1:0] win;
  logic [SEQ_W-1:0] oldest_n;
  logic [SEQ_W-1:0] tx_b;
  logic [SEQ_W-1:0] rp_b;
  logic [SEQ_W-1:0] load_seq;
  logic [RW-1:0]    cnt_base;
  logic             is_ack;
  logic             is_nak;
  logic             in_win;
  logic             purge;
  logic             cnt_clr;
  logic             pend_set;
  logic             pend_b;
  logic             wr;
  logic             fin;
  logic             adv;
  logic             can_pick;
  logic             rep_go;
  logic             rep_cont;
  logic             snd_go;
  logic             load;
  logic             roll_hit;

  always_comb begin
    outstanding = next_seq - oldest_seq;
    count       = outstanding[AW:0];
    ready       = (outstanding < SEQ_W'(DEPTH)) && (state != REPLAY);
    wr          = we && ready;
    dout        = shreg[IN_W-1 -: OUT_W];

    // ACK/NAK window is [oldest_seq, tx_seq-1], measured as a modular offset.
    is_ack   = (ack_nack == 2'b01);
    is_nak   = (ack_nack == 2'b10);
    s_off    = seq - oldest_seq;
    win      = tx_seq - oldest_seq;
    in_win   = (s_off < win);
    purge    = (is_ack || is_nak) && in_win;
    cnt_clr  = is_ack && in_win;
    oldest_n = purge ? (seq + SEQ_W'(1)) : oldest_seq;
    // An ACK in the same cycle swallows the timer pulse; a NAK replays anyway.
    pend_set = is_nak || (tim_out && !is_ack && (outstanding != '0));
    pend_b   = pend || pend_set;

    fin  = dout_valid && busy_n && (beat_idx == BW'(BEATS - 1));
    adv  = dout_valid && busy_n && !fin;
    tx_b = tx_seq + ((state == SEND && fin) ? SEQ_W'(1) : '0);

    // Next replay slot; if a purge overtook it, skip ahead to the new oldest.
    rp_b = cur_seq + SEQ_W'(1);
    if ((tx_b - rp_b) > (tx_b - oldest_n)) rp_b = oldest_n;

    // A new TLP is only chosen between TLPs, so a replay never truncates one.
    can_pick = (state == IDLE) || fin;
    rep_go   = can_pick && pend_b && (oldest_n != tx_b);
    rep_cont = can_pick && !rep_go && (state == REPLAY) && (rp_b != tx_b);
    snd_go   = can_pick && !rep_go && !rep_cont && (tx_b != next_seq);
    load     = rep_go || rep_cont || snd_go;
    load_seq = rep_go ? oldest_n : (rep_cont ? rp_b : tx_b);

    state_n = state;
    if (can_pick) begin
      if (rep_go || rep_cont) state_n = REPLAY;
      else if (snd_go)        state_n = SEND;
      else                    state_n = IDLE;
    end

    cnt_base = cnt_clr ? '0 : replay_cnt;
    roll_hit = rep_go && (cnt_base == RW'(REPLAY_MAX));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      oldest_seq      <= '0;
      tx_seq          <= '0;
      cur_seq         <= '0;
      next_seq        <= '0;
      beat_idx        <= '0;
      pend            <= 1'b0;
      replay_cnt      <= '0;
      replay_rollover <= 1'b0;
      dout_valid      <= 1'b0;
      dout_sof        <= 1'b0;
      shreg           <= '0;
    end else begin
      if (wr) next_seq <= next_seq + SEQ_W'(1);
      oldest_seq      <= oldest_n;
      tx_seq          <= tx_b;
      state           <= state_n;
      // Pending is consumed at every pick point; with nothing transmitted
      // outstanding there is nothing to replay and it is dropped.
      pend            <= can_pick ? 1'b0 : pend_b;
      replay_rollover <= roll_hit;
      if (rep_go) replay_cnt <= roll_hit ? '0 : (cnt_base + RW'(1));
      else        replay_cnt <= cnt_base;

      // Output stage: the word is latched whole, so a purge or overwrite of
      // its slot cannot corrupt a TLP already on the link.
      if (load) begin
        cur_seq    <= load_seq;
        shreg      <= mem[load_seq[AW-1:0]];
        beat_idx   <= '0;
        dout_valid <= 1'b1;
        dout_sof   <= 1'b1;
      end else if (adv) begin
        shreg      <= shreg << OUT_W;
        beat_idx   <= beat_idx + BW'(1);
        dout_sof   <= 1'b0;
      end else if (fin) begin
        dout_valid <= 1'b0;
        dout_sof   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[next_seq[AW-1:0]] <= din;
  end

endmodule
